// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, funct3 codes, one-hot ALU indices
// and immediate extraction helpers.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // bit positions inside funct3oh, shared with ALU_unit
    localparam int OH_ADD  = 0;
    localparam int OH_SLL  = 1;
    localparam int OH_SLT  = 2;
    localparam int OH_SLTU = 3;
    localparam int OH_XOR  = 4;
    localparam int OH_SR   = 5;
    localparam int OH_OR   = 6;
    localparam int OH_AND  = 7;

    function automatic logic [7:0] f3_onehot(input logic [2:0] f3);
        return 8'b1 << f3;
    endfunction

    function automatic logic [31:0] i_imm(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one
// synchronous write port, x0 reads as zero and ignores writes.
module regfile_2r1w #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
    assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_issue_decode.sv
// Decode/issue stage feeding the ALU: decodes OP-IMM/OP/BRANCH, reads
// operands with writeback bypass and holds a one-entry output bundle.
module alu_issue_decode
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            isALUimm,
    output logic            isALUreg,
    output logic            isBranch,
    output logic [7:0]      funct3oh,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic            illegal
);

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      ra1;
    logic [4:0]      ra2;
    logic [XLEN-1:0] rf1;
    logic [XLEN-1:0] rf2;
    logic            wb_hit;
    logic [XLEN-1:0] v1;
    logic [XLEN-1:0] v2;
    logic            accept;

    logic            is_opimm;
    logic            is_op;
    logic            is_br;

    logic            d_imm_f;
    logic            d_reg_f;
    logic            d_br_f;
    logic [7:0]      d_f3oh;
    logic [6:0]      d_f7;
    logic [XLEN-1:0] d_rs2;
    logic [XLEN-1:0] d_imm;
    logic [4:0]      d_rd;
    logic            d_ill;
    logic            d_rs2reg;

    logic [4:0]      ra1_q;
    logic [4:0]      ra2_q;
    logic            rs2reg_q;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign ra1 = instr[19:15];
    assign ra2 = instr[24:20];

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk (clk),
        .ra1 (ra1),
        .ra2 (ra2),
        .rd1 (rf1),
        .rd2 (rf2),
        .we  (wb_we),
        .wa  (wb_rd),
        .wd  (wb_data)
    );

    assign wb_hit   = wb_we && (wb_rd != 5'd0);
    assign v1       = (wb_hit && wb_rd == ra1) ? wb_data : rf1;
    assign v2       = (wb_hit && wb_rd == ra2) ? wb_data : rf2;
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign is_opimm = (opc == OPC_OPIMM);
    assign is_op    = (opc == OPC_OP);
    assign is_br    = (opc == OPC_BRANCH)
                   && (f3 != F3_SLT) && (f3 != F3_SLTU);

    always_comb begin
        d_imm_f  = 1'b0;
        d_reg_f  = 1'b0;
        d_br_f   = 1'b0;
        d_f3oh   = 8'd0;
        d_f7     = 7'd0;
        d_rs2    = v2;
        d_imm    = '0;
        d_rd     = 5'd0;
        d_ill    = 1'b0;
        d_rs2reg = 1'b1;
        unique case (1'b1)
            is_opimm: begin
                d_imm_f  = 1'b1;
                d_f3oh   = f3_onehot(f3);
                // only shifts carry funct7 on OP-IMM
                if (f3 == F3_SLL || f3 == F3_SR) begin
                    d_f7 = instr[31:25];
                end
                d_rs2    = i_imm(instr);
                d_imm    = i_imm(instr);
                d_rd     = instr[11:7];
                d_rs2reg = 1'b0;
            end
            is_op: begin
                d_reg_f = 1'b1;
                d_f3oh  = f3_onehot(f3);
                d_f7    = instr[31:25];
                d_rd    = instr[11:7];
            end
            is_br: begin
                d_br_f = 1'b1;
                d_f3oh = f3_onehot(f3);
                d_imm  = b_imm(instr);
            end
            default: begin
                d_ill = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            isALUimm  <= 1'b0;
            isALUreg  <= 1'b0;
            isBranch  <= 1'b0;
            funct3oh  <= 8'd0;
            funct7    <= 7'd0;
            rs1       <= '0;
            rs2       <= '0;
            imm       <= '0;
            rd        <= 5'd0;
            illegal   <= 1'b0;
            ra1_q     <= 5'd0;
            ra2_q     <= 5'd0;
            rs2reg_q  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            isALUimm  <= d_imm_f;
            isALUreg  <= d_reg_f;
            isBranch  <= d_br_f;
            funct3oh  <= d_f3oh;
            funct7    <= d_f7;
            rs1       <= v1;
            rs2       <= d_rs2;
            imm       <= d_imm;
            rd        <= d_rd;
            illegal   <= d_ill;
            ra1_q     <= ra1;
            ra2_q     <= ra2;
            rs2reg_q  <= d_rs2reg;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid && wb_hit) begin
            // stalled bundle tracks late writebacks to its sources
            if (wb_rd == ra1_q) begin
                rs1 <= wb_data;
            end
            if (rs2reg_q && wb_rd == ra2_q) begin
                rs2 <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_decode.sv
// Scoreboard bench for alu_issue_decode: expected bundles are queued
// when an instruction is sent and compared when it issues.
module tb_alu_issue_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic        isALUimm;
    logic        isALUreg;
    logic        isBranch;
    logic [7:0]  funct3oh;
    logic [6:0]  funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        fi;
        logic        fr;
        logic        fb;
        logic [7:0]  oh;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic [4:0]  rd;
        logic        ill;
    } bundle_t;

    bundle_t q[$];

    always #5 clk = ~clk;

    alu_issue_decode dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .isALUimm  (isALUimm),
        .isALUreg  (isALUreg),
        .isBranch  (isBranch),
        .funct3oh  (funct3oh),
        .funct7    (funct7),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .rd        (rd),
        .illegal   (illegal)
    );

    function automatic bundle_t mk(input logic [2:0] t,
                                   input logic [7:0] oh,
                                   input logic [6:0] f7,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [31:0] im,
                                   input logic [4:0] r,
                                   input logic ill);
        bundle_t e;
        e = {t, oh, f7, a, b, im, r, ill};
        return e;
    endfunction

    function automatic bundle_t act();
        return {isALUimm, isALUreg, isBranch, funct3oh, funct7,
                rs1, rs2, imm, rd, illegal};
    endfunction

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        wb_we = 1'b1;
        wb_rd = r;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_we = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        in_valid = 1'b1;
        instr = w;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_ready instr=%h in_ready=%b want 1", w, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic take(input string nm);
        int n = 0;
        bundle_t e;
        bundle_t a;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = '0;
        if (q.size() > 0) e = q.pop_front();
        a = act();
        total++;
        if (out_valid !== 1'b1 || a !== e) begin
            bad++;
            $display("FAIL %s valid=%b got=%h want=%h", nm, out_valid, a, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        instr = '0;
        wb_we = 1'b0;
        wb_rd = '0;
        wb_data = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || act() !== '0) begin
            bad++;
            $display("FAIL reset_state valid=%b got=%h want 0", out_valid, act());
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want 0", in_ready);
        end
        rst = 1'b0;
        wr(5'd1, 32'd10);
        wr(5'd6, 32'd8);
        wr(5'd7, 32'd5);
    endtask

    task automatic test_opimm();
        q.push_back(mk(3'b100, 8'h01, 7'h00, 32'd10, 32'hFFFFFFFF,
                       32'hFFFFFFFF, 5'd3, 1'b0));
        send(32'hFFF08193);
        take("addi_m1");
    endtask

    task automatic test_op();
        q.push_back(mk(3'b010, 8'h01, 7'h20, 32'd8, 32'd5,
                       32'd0, 5'd5, 1'b0));
        send(32'h407302B3);
        take("sub");
        q.push_back(mk(3'b010, 8'h01, 7'h00, 32'd0, 32'd0,
                       32'd0, 5'd5, 1'b0));
        send(32'h000002B3);
        take("add_x0_x0");
    endtask

    task automatic test_shift_f7();
        q.push_back(mk(3'b100, 8'h20, 7'h20, 32'd8, 32'h0000040C,
                       32'h0000040C, 5'd5, 1'b0));
        send(32'h40C35293);
        take("srai");
        q.push_back(mk(3'b100, 8'h01, 7'h00, 32'd8, 32'h00000400,
                       32'h00000400, 5'd5, 1'b0));
        send(32'h40030293);
        take("addi_no_f7");
    endtask

    task automatic test_branch();
        q.push_back(mk(3'b001, 8'h40, 7'h00, 32'd8, 32'd5,
                       32'hFFFFFFF8, 5'd0, 1'b0));
        send(32'hFE736CE3);
        take("bltu");
        q.push_back(mk(3'b000, 8'h00, 7'h00, 32'd0, 32'd0,
                       32'd0, 5'd0, 1'b1));
        send(32'h00002063);
        take("branch_f3_010");
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[3];
        bundle_t e[3];
        bundle_t a;
        w[0] = 32'hFFF08193;
        w[1] = 32'h407302B3;
        w[2] = 32'hFE736CE3;
        e[0] = mk(3'b100, 8'h01, 7'h00, 32'd10, 32'hFFFFFFFF,
                  32'hFFFFFFFF, 5'd3, 1'b0);
        e[1] = mk(3'b010, 8'h01, 7'h20, 32'd8, 32'd5, 32'd0, 5'd5, 1'b0);
        e[2] = mk(3'b001, 8'h40, 7'h00, 32'd8, 32'd5,
                  32'hFFFFFFF8, 5'd0, 1'b0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        instr = w[0];
        q.push_back(e[0]);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            a = act();
            total++;
            if (out_valid !== 1'b1 || a !== q[0]) begin
                bad++;
                $display("FAIL b2b_%0d valid=%b got=%h want=%h",
                         i, out_valid, a, q[0]);
            end
            void'(q.pop_front());
            if (i < 2) begin
                instr = w[i+1];
                q.push_back(e[i+1]);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        q.push_back(mk(3'b010, 8'h01, 7'h20, 32'h55, 32'd5,
                       32'd0, 5'd5, 1'b0));
        send(32'h407302B3);
        total++;
        if (in_ready !== 1'b0 || rs1 !== 32'd8) begin
            bad++;
            $display("FAIL stall_hold in_ready=%b rs1=%h want 0/8", in_ready, rs1);
        end
        wr(5'd6, 32'h55);
        total++;
        if (in_ready !== 1'b0 || rs1 !== 32'h55 || rs2 !== 32'd5) begin
            bad++;
            $display("FAIL stall_refresh in_ready=%b rs1=%h rs2=%h want 0/55/5",
                     in_ready, rs1, rs2);
        end
        @(posedge clk);
        #1;
        take("stall_sub");
        wb_we = 1'b1;
        wb_rd = 5'd7;
        wb_data = 32'h77;
        q.push_back(mk(3'b001, 8'h40, 7'h00, 32'h55, 32'h77,
                       32'hFFFFFFF8, 5'd0, 1'b0));
        send(32'hFE736CE3);
        wb_we = 1'b0;
        take("bypass_rs2");
    endtask

    task automatic test_illegal();
        q.push_back(mk(3'b000, 8'h00, 7'h00, 32'd0, 32'd0,
                       32'd0, 5'd0, 1'b1));
        send(32'h000012B7);
        take("lui_illegal");
    endtask

    task automatic test_rst_midstall();
        out_ready = 1'b0;
        send(32'hFFF08193);
        rst = 1'b1;
        in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_in_ready got=%b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || act() !== '0) begin
            bad++;
            $display("FAIL rst_midstall valid=%b got=%h want 0", out_valid, act());
        end
        out_ready = 1'b1;
    endtask

    task automatic test_x0();
        wr(5'd0, 32'hDEAD);
        wb_we = 1'b1;
        wb_rd = 5'd0;
        wb_data = 32'hBEEF;
        q.push_back(mk(3'b100, 8'h01, 7'h00, 32'd0, 32'd5,
                       32'd5, 5'd3, 1'b0));
        send(32'h00500193);
        wb_we = 1'b0;
        take("x0_read");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_opimm();
        test_op();
        test_shift_f7();
        test_branch();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_rst_midstall();
        test_x0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
